// File: rtl/string_compare_engine_if.sv
// Bundle of FIFO-side and control/result signals for the string compare engine.
// The engine uses the master view; the Avalon slave (or a bench) uses the slave view.
interface string_compare_engine_if #(
    parameter int IDX_W = 6
);
    logic             go;
    logic [31:0]      a_data;
    logic             a_empty;
    logic             a_pop;
    logic [31:0]      b_data;
    logic             b_empty;
    logic             b_pop;
    logic             busy;
    logic             done;
    logic             equal;
    logic [IDX_W-1:0] char_index;
    logic [31:0]      result;

    modport master (
        input  go, a_data, a_empty, b_data, b_empty,
        output a_pop, b_pop, busy, done, equal, char_index, result
    );

    modport slave (
        output go, a_data, a_empty, b_data, b_empty,
        input  a_pop, b_pop, busy, done, equal, char_index, result
    );
endinterface

// File: rtl/string_compare_engine.sv
// strcmp-style engine: pops packed 4-char words from FIFO A and FIFO B in lockstep and
// reports the signed byte difference, the stop index and an equality flag.
module string_compare_engine #(
    parameter int MAX_WORDS = 8,
    parameter int IDX_W     = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    string_compare_engine_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LIMIT = IDX_W'(MAX_WORDS * 4);

    state_t           state_q, state_d;
    logic [31:0]      wa_q, wa_d;
    logic [31:0]      wb_q, wb_d;
    logic [IDX_W-1:0] base_q, base_d;
    logic [IDX_W-1:0] char_index_q, char_index_d;
    logic [31:0]      result_q, result_d;
    logic             done_q, done_d;
    logic             equal_q, equal_d;
    logic             pop;

    logic             hit;
    logic [1:0]       hit_k;
    logic [7:0]       byte_a;
    logic [7:0]       byte_b;
    logic [8:0]       diff;
    logic [IDX_W-1:0] next_base;

    // First byte (char0 in the MSBs) that differs or is a NUL in word A.
    always_comb begin
        hit    = 1'b0;
        hit_k  = 2'd0;
        byte_a = 8'h00;
        byte_b = 8'h00;
        for (int k = 0; k < 4; k++) begin
            if (!hit && ((wa_q[31-8*k -: 8] != wb_q[31-8*k -: 8]) ||
                         (wa_q[31-8*k -: 8] == 8'h00))) begin
                hit    = 1'b1;
                hit_k  = 2'(k);
                byte_a = wa_q[31-8*k -: 8];
                byte_b = wb_q[31-8*k -: 8];
            end
        end
        diff      = {1'b0, byte_a} - {1'b0, byte_b};
        next_base = base_q + IDX_W'(4);
    end

    always_comb begin
        state_d      = state_q;
        wa_d         = wa_q;
        wb_d         = wb_q;
        base_d       = base_q;
        char_index_d = char_index_q;
        result_d     = result_q;
        done_d       = done_q;
        equal_d      = equal_q;
        pop          = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.go) begin
                    done_d       = 1'b0;
                    equal_d      = 1'b0;
                    result_d     = 32'd0;
                    char_index_d = '0;
                    base_d       = '0;
                    state_d      = FETCH;
                end
            end
            FETCH: begin
                if (!bus.a_empty && !bus.b_empty) begin
                    pop     = 1'b1;
                    wa_d    = bus.a_data;
                    wb_d    = bus.b_data;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    char_index_d = base_q + IDX_W'(hit_k);
                    result_d     = {{23{diff[8]}}, diff};
                    equal_d      = (diff == 9'd0);
                    done_d       = 1'b1;
                    state_d      = DONE;
                end else begin
                    base_d = next_base;
                    if (next_base == LIMIT) begin
                        equal_d      = 1'b1;
                        result_d     = 32'd0;
                        char_index_d = LIMIT;
                        done_d       = 1'b1;
                        state_d      = DONE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wa_q         <= 32'd0;
            wb_q         <= 32'd0;
            base_q       <= '0;
            char_index_q <= '0;
            result_q     <= 32'd0;
            done_q       <= 1'b0;
            equal_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wa_q         <= wa_d;
            wb_q         <= wb_d;
            base_q       <= base_d;
            char_index_q <= char_index_d;
            result_q     <= result_d;
            done_q       <= done_d;
            equal_q      <= equal_d;
        end
    end

    // Pops are gated by reset so an abort in FETCH never consumes a word.
    assign bus.a_pop      = pop & ~reset;
    assign bus.b_pop      = pop & ~reset;
    assign bus.busy       = (state_q == FETCH) || (state_q == COMPARE);
    assign bus.done       = done_q;
    assign bus.equal      = equal_q;
    assign bus.char_index = char_index_q;
    assign bus.result     = result_q;

endmodule
